// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: write/read controller for a three-line pixel buffer.
// One line RAM takes the incoming line while the other two are read at the
// same column. Together with the registered input pixel they give a vertical
// three-tap window (lines n-2, n-1, n) that is one cycle behind the input.
//
// Parameters:
//   ADDR_WIDTH - line RAM address width
//   DATA_WIDTH - pixel width
//   LENGTH     - pixels per line (2 .. 2**ADDR_WIDTH)
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   in_valid, in_sof, in_data       - pixel stream in (in_sof marks frame start)
//   ram_addr, ram_w_en, ram_din     - shared address/data, per-RAM write enable
//   ram_dout0..2                    - registered read data of RAMs 0..2
//   tap_top, tap_mid, tap_cur       - column-aligned pixels of lines n-2, n-1, n
//   out_valid, out_eol              - tap set valid / last column of its line
// Configuration:
//   LINE_BUF_CTRL_BORDER_EN - when defined, output starts on the second line
//   of a frame, with the top tap replicating the middle tap on that line.
module line_buf_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 1920
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [2:0]            ram_w_en,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout0,
    input  logic [DATA_WIDTH-1:0] ram_dout1,
    input  logic [DATA_WIDTH-1:0] ram_dout2,
    output logic [DATA_WIDTH-1:0] tap_top,
    output logic [DATA_WIDTH-1:0] tap_mid,
    output logic [DATA_WIDTH-1:0] tap_cur,
    output logic                  out_valid,
    output logic                  out_eol
);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LENGTH - 1);
`ifdef LINE_BUF_CTRL_BORDER_EN
    // FILL ends when the line being completed is the first of the frame.
    localparam logic [1:0] RUN_AFTER = 2'd0;
`else
    // FILL ends when the line being completed is the second of the frame.
    localparam logic [1:0] RUN_AFTER = 2'd1;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] col, col_nxt;
    logic [1:0]            wr_sel, wr_sel_nxt;
    logic [1:0]            lines_filled, lines_filled_nxt;
    logic [1:0]            wr_sel_d;
    logic [1:0]            wr_sel_eff;
    logic                  sof_acc;
    logic                  pix_acc;
    logic                  at_eol;
`ifdef LINE_BUF_CTRL_BORDER_EN
    logic                  border_d;
`endif

    always_comb begin
        sof_acc    = rst_n & in_valid & in_sof;
        pix_acc    = rst_n & in_valid & (in_sof | (state != IDLE));
        at_eol     = (col == LAST_COL);
        wr_sel_eff = sof_acc ? 2'd0 : wr_sel;

        state_nxt        = state;
        col_nxt          = col;
        wr_sel_nxt       = wr_sel;
        lines_filled_nxt = lines_filled;

        if (sof_acc) begin
            // The sof pixel itself is column 0, so the next one lands at 1.
            state_nxt        = FILL;
            col_nxt          = ADDR_WIDTH'(1);
            wr_sel_nxt       = 2'd0;
            lines_filled_nxt = 2'd0;
        end else if (pix_acc) begin
            if (at_eol) begin
                col_nxt          = '0;
                wr_sel_nxt       = (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
                lines_filled_nxt = (lines_filled == 2'd2) ? 2'd2 : lines_filled + 2'd1;
                if (state == FILL && lines_filled == RUN_AFTER)
                    state_nxt = RUN;
            end else begin
                col_nxt = col + ADDR_WIDTH'(1);
            end
        end

        ram_addr = sof_acc ? '0 : col;
        ram_din  = in_data;
        ram_w_en = '0;
        if (pix_acc) begin
            case (wr_sel_eff)
                2'd0:    ram_w_en = 3'b001;
                2'd1:    ram_w_en = 3'b010;
                default: ram_w_en = 3'b100;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            col          <= '0;
            wr_sel       <= '0;
            lines_filled <= '0;
            wr_sel_d     <= '0;
            tap_cur      <= '0;
            out_valid    <= 1'b0;
            out_eol      <= 1'b0;
`ifdef LINE_BUF_CTRL_BORDER_EN
            border_d     <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            col          <= col_nxt;
            wr_sel       <= wr_sel_nxt;
            lines_filled <= lines_filled_nxt;
            tap_cur      <= in_data;
            // A restarting sof pixel never produces taps, even from RUN.
            out_valid    <= pix_acc & ~sof_acc & (state == RUN);
            out_eol      <= pix_acc & ~sof_acc & (state == RUN) & at_eol;
            if (pix_acc) begin
                wr_sel_d <= wr_sel_eff;
`ifdef LINE_BUF_CTRL_BORDER_EN
                border_d <= ~sof_acc & (lines_filled == 2'd1);
`endif
            end
        end
    end

    // RAM read data is already registered, so the taps only select among the
    // two RAMs not written with the pixel; they read zero while out_valid is
    // low so reset and idle cycles present a clean all-zero tap set.
    always_comb begin
        tap_top = '0;
        tap_mid = '0;
        if (out_valid) begin
            case (wr_sel_d)
                2'd0: begin
                    tap_top = ram_dout1;
                    tap_mid = ram_dout2;
                end
                2'd1: begin
                    tap_top = ram_dout2;
                    tap_mid = ram_dout0;
                end
                default: begin
                    tap_top = ram_dout0;
                    tap_mid = ram_dout1;
                end
            endcase
`ifdef LINE_BUF_CTRL_BORDER_EN
            if (border_d)
                tap_top = tap_mid;
`endif
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: drives line_buf_ctrl (LENGTH=4) with directed frames and
// randomized streams, models the three line RAMs, and checks every output
// against a frame-level reference that stores each received line by number.
// Honours LINE_BUF_CTRL_BORDER_EN like the design.
module tb_line_buf_ctrl;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int L  = 4;
`ifdef LINE_BUF_CTRL_BORDER_EN
    localparam int FIRST_OUT_LINE = 1;
`else
    localparam int FIRST_OUT_LINE = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] ram_addr;
    logic [2:0]    ram_w_en;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout0, ram_dout1, ram_dout2;
    logic [DW-1:0] tap_top, tap_mid, tap_cur;
    logic          out_valid, out_eol;

    always #5 clk = ~clk;

    line_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_din(ram_din),
        .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
        .tap_top(tap_top), .tap_mid(tap_mid), .tap_cur(tap_cur),
        .out_valid(out_valid), .out_eol(out_eol)
    );

    // Three single-port RAMs with registered read data.
    logic [DW-1:0] mem0 [0:(1<<AW)-1];
    logic [DW-1:0] mem1 [0:(1<<AW)-1];
    logic [DW-1:0] mem2 [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_w_en[0]) mem0[ram_addr] <= ram_din; else ram_dout0 <= mem0[ram_addr];
        if (ram_w_en[1]) mem1[ram_addr] <= ram_din; else ram_dout1 <= mem1[ram_addr];
        if (ram_w_en[2]) mem2[ram_addr] <= ram_din; else ram_dout2 <= mem2[ram_addr];
    end

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference: every line of the current frame kept by its line number.
    logic [DW-1:0] pix [0:63][0:L-1];
    bit            active = 0;
    int            line = 0;
    int            col = 0;
    bit            exp_valid = 0, exp_eol = 0;
    logic [DW-1:0] exp_top = '0, exp_mid = '0, exp_cur = '0;

    task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
        bit       acc;
        logic [2:0] exp_wen;
        @(negedge clk);
        check("out_valid", out_valid, exp_valid);
        check("out_eol", out_eol, exp_eol);
        if (exp_valid) begin
            check("tap_top", tap_top, exp_top);
            check("tap_mid", tap_mid, exp_mid);
            check("tap_cur", tap_cur, exp_cur);
        end
        in_valid = v; in_sof = s; in_data = d;
        #1;
        acc = v && (s || active);
        if (acc && s) begin
            active = 1; line = 0; col = 0;
        end
        exp_wen = acc ? (3'b001 << (line % 3)) : 3'b000;
        check("ram_w_en", ram_w_en, exp_wen);
        if (acc) begin
            check("ram_addr", ram_addr, col);
            check("ram_din", ram_din, d);
        end
        exp_valid = 0; exp_eol = 0;
        if (acc) begin
            pix[line % 64][col] = d;
            if (line >= FIRST_OUT_LINE) begin
                exp_valid = 1;
                exp_eol   = (col == L - 1);
                exp_mid   = pix[(line - 1) % 64][col];
                exp_top   = (line >= 2) ? pix[(line - 2) % 64][col] : exp_mid;
                exp_cur   = d;
            end
            col++;
            if (col == L) begin
                col = 0;
                line++;
            end
        end
        @(posedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 0; in_valid = 1; in_sof = 0; in_data = 16'hBEEF;
        #1;
        check("rst_w_en", ram_w_en, 3'b000);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_eol", out_eol, 1'b0);
        check("rst_tap_top", tap_top, '0);
        check("rst_tap_mid", tap_mid, '0);
        check("rst_tap_cur", tap_cur, '0);
        rst_n = 1; in_valid = 0;
        active = 0; exp_valid = 0; exp_eol = 0;
    endtask

    // One frame line of value 16*ln+c; gap=1 inserts an idle cycle per pixel.
    task automatic send_line(input int ln, input bit first, input bit gap);
        for (int c = 0; c < L; c++) begin
            step(1'b1, first && (c == 0), DW'(16 * ln + c));
            if (gap) step(1'b0, 1'b0, 16'hDEAD);
        end
    endtask

    initial begin
        reset_pulse();

        // Continuous 5-line frame.
        for (int ln = 0; ln < 5; ln++) send_line(ln, ln == 0, 1'b0);
        step(1'b0, 1'b0, '0);

        // Frame with valid toggling once the window is full.
        for (int ln = 0; ln < 4; ln++) send_line(ln, ln == 0, ln >= 2);

        // Mid-line restart at line 3 col 2, then a full new frame.
        for (int ln = 0; ln < 3; ln++) send_line(ln, ln == 0, 1'b0);
        step(1'b1, 1'b0, 16'h30);
        step(1'b1, 1'b0, 16'h31);
        step(1'b1, 1'b1, 16'h100);
        for (int c = 1; c < L; c++) step(1'b1, 1'b0, DW'(16'h100 + c));
        for (int ln = 1; ln < 4; ln++) send_line(ln + 16, 1'b0, 1'b0);

        // Reset mid-RUN, then pixels without sof must be ignored.
        reset_pulse();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'($urandom));
        step(1'b0, 1'b0, '0);

        // Randomized streams.
        for (int i = 0; i < 1500; i++) begin
            logic v, s;
            v = ($urandom % 4) != 0;
            s = (($urandom % 50) == 0) || !active || line >= 60;
            step(v, v ? s : 1'b0, DW'($urandom));
            if (($urandom % 400) == 0) reset_pulse();
        end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 11: address width driven to each line RAM.
REQ-002 Parameter DATA_WIDTH, default 16: pixel width.
REQ-003 Parameter LENGTH, default 1920: pixels per line; SHALL be at least 2 and at most 2^ADDR_WIDTH.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1: in_data carries a pixel this cycle.
REQ-007 Port in_sof, input, 1: start of frame; qualified by in_valid.
REQ-008 Port in_data, input, DATA_WIDTH: incoming pixel.
REQ-009 Port ram_addr, output, ADDR_WIDTH: address shared by all three line RAMs.
REQ-010 Port ram_w_en, output, 3: per-RAM write enable; a RAM reads when its bit is 0.
REQ-011 Port ram_din, output, DATA_WIDTH: write data shared by all three RAMs.
REQ-012 Ports ram_dout0, ram_dout1, ram_dout2, input, DATA_WIDTH each: registered read data of RAMs 0, 1 and 2.
REQ-013 Ports tap_top, tap_mid, tap_cur, output, DATA_WIDTH each: the column-aligned pixels of lines n-2, n-1 and n.
REQ-014 Port out_valid, output, 1: the taps are valid this cycle.
REQ-015 Port out_eol, output, 1: the tap set is the last column of its line; SHALL be asserted only together with out_valid.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, FILL and RUN.
REQ-017 The FSM SHALL transition as follows:
- IDLE to FILL on in_valid & in_sof.
- FILL to RUN when the second complete line has been written.
- Any state to FILL on in_valid & in_sof.
REQ-018 In IDLE, in_valid pixels without in_sof SHALL be ignored: no RAM write and no counter change.
REQ-019 The column counter col (0..LENGTH-1) SHALL advance on each accepted pixel and wrap from LENGTH-1 to 0.
REQ-020 On wrap, wr_sel SHALL rotate 0->1->2->0 and lines_filled SHALL increment, saturating at 2.
REQ-021 An accepted in_sof pixel SHALL be written as column 0 of RAM 0, and SHALL set col to 1, wr_sel to 0 and lines_filled to 0.
REQ-022 ram_addr SHALL be combinational and equal to col, or to 0 when in_sof is accepted.
REQ-023 ram_din SHALL equal in_data.
REQ-024 ram_w_en[wr_sel] SHALL equal the pixel-accepted condition; the other two bits SHALL be 0.
REQ-025 The two non-written RAMs SHALL read the same address in the same cycle.
REQ-026 Latency SHALL be 1 cycle: taps and out_valid appear in the cycle after the pixel is accepted.
REQ-027 tap_cur SHALL be the registered in_data.
REQ-028 tap_top SHALL be ram_dout[(wr_sel_d+1)%3] and tap_mid SHALL be ram_dout[(wr_sel_d+2)%3], where wr_sel_d is wr_sel registered with the pixel.
REQ-029 out_valid SHALL be the registered (pixel accepted & state RUN).
REQ-030 out_eol SHALL be the registered (pixel accepted & col==LENGTH-1 & state RUN).
REQ-031 While in_valid=0, counters, state and wr_sel SHALL hold, ram_w_en SHALL be 0, and out_valid SHALL drop the following cycle.
REQ-032 An in_sof arriving mid-line SHALL discard the partial line and restart per REQ-021; out_valid SHALL be 0 from the following cycle until RUN is re-entered.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL set:
- state to IDLE;
- col, wr_sel, lines_filled and wr_sel_d to 0;
- tap_top, tap_mid, tap_cur, out_valid and out_eol to 0.
REQ-034 While rst_n=0, ram_w_en SHALL be 0; RAM contents SHALL NOT be cleared by this block.

Configuration
REQ-035 Macro LINE_BUF_CTRL_BORDER_EN SHALL select border handling.
- Defined: FILL SHALL go to RUN after the first complete line; while lines_filled==1, tap_top SHALL equal tap_mid (top-border replication).
- Undefined: RUN SHALL be entered only after two complete lines, and no replication logic SHALL be present.

Verification (LENGTH=4, macro undefined unless stated)
REQ-036 Scenario: reset, then a frame of 3 lines with pixel value = 16*line+col and in_valid continuous.
- out_valid SHALL first assert in the cycle after line-2 col-0 is accepted.
- The taps SHALL then read (0x00, 0x10, 0x20), then (0x01, 0x11, 0x21), and so on.
- out_eol SHALL assert with (0x03, 0x13, 0x23).
REQ-037 Scenario: 5 lines are streamed.
- ram_w_en SHALL sequence 001, 010, 100, 001, 010.
- Line 4 taps SHALL be (0x20, 0x30, 0x40).
REQ-038 Scenario: in_valid toggles 1/0 every cycle in RUN.
- Tap values SHALL match REQ-036.
- out_valid SHALL be a 1/0 pattern delayed by 1 cycle.
REQ-039 Scenario: in_sof at line-3 col-2.
- out_valid SHALL be 0 from the next cycle.
- The new pixel SHALL be written to RAM 0, address 0.
- RUN SHALL re-enter after two further lines.
REQ-040 Scenario: rst_n=0 for 1 cycle mid-RUN.
- All outputs SHALL be 0 on the next cycle.
- Pixels without in_sof SHALL NOT write the RAMs.
REQ-041 Scenario: LINE_BUF_CTRL_BORDER_EN defined.
- out_valid SHALL first assert on line 1 with taps (0x00, 0x00, 0x10).
- Line 2 taps SHALL be (0x00, 0x10, 0x20).
